// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with load/start/pause control and expiry flag.
// Optional feature macro: TIMER_WARN_EN builds the last-ten-seconds warn flag;
// without it, warn is tied low and no comparator is built.
module bcd_countdown_timer #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        expired,
    output logic        tick,
    output logic        load_err,
    output logic        warn
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e        state_q, state_d;
    logic [15:0]   time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          load_err_q, load_err_d;
    logic [15:0]   time_dec;
    logic          wrap;
    logic          load_ok;

    // One-second BCD decrement with borrow chain; never called at 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign time_dec = bcd_dec(time_q);
    assign wrap     = (presc_q == PRESC_MAX);
    assign load_ok  = (load_val[15:12] <= 4'd9) && (load_val[11:8] <= 4'd9) &&
                      (load_val[7:4] <= 4'd5) && (load_val[3:0] <= 4'd9);

    // Next-state logic: load beats pause beats start.
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        presc_d    = presc_q;
        tick_d     = 1'b0;
        load_err_d = 1'b0;
        if (state_q != StRun && load_en) begin
            // Any load outside RUN consumes the cycle, accepted or not.
            if (load_ok) begin
                time_d  = load_val;
                state_d = StIdle;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    presc_d = wrap ? '0 : presc_q + PW'(1);
                    if (wrap) begin
                        time_d = time_dec;
                        tick_d = 1'b1;
                    end
                    // Reaching 00:00 is final even if pause arrives on the same edge.
                    if (wrap && time_dec == 16'h0000) begin
                        state_d = StDone;
                    end else if (pause) begin
                        state_d = StPause;
                    end
                end
                StIdle: begin
                    if (start && time_q != 16'h0000) begin
                        state_d = StRun;
                        presc_d = '0;
                    end
                end
                StPause: begin
                    // Prescaler kept so the partial second is finished on resume.
                    if (start && time_q != 16'h0000) begin
                        state_d = StRun;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            time_q     <= 16'h0000;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            load_err_q <= load_err_d;
        end
    end

    assign time_bcd = time_q;
    assign running  = (state_q == StRun);
    assign expired  = (state_q == StDone);
    assign tick     = tick_q;
    assign load_err = load_err_q;

`ifdef TIMER_WARN_EN
    logic warn_q, warn_d;

    // Warn while active with 00:01..00:10 showing; plain compare is valid on BCD.
    always_comb begin
        warn_d = (state_d == StRun || state_d == StPause) && (time_d[15:8] == 8'h00) &&
                 (time_d[7:0] != 8'h00) && (time_d[7:0] <= 8'h10);
    end

    // Warn register, updates alongside time_bcd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign warn = warn_q;
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: seconds-based reference model checked every cycle,
// plus directed literal checks. Honours TIMER_WARN_EN for the warn expectation.
module tb_bcd_countdown_timer;

    localparam int TD = 4;
`ifdef TIMER_WARN_EN
    localparam bit WarnOn = 1'b1;
`else
    localparam bit WarnOn = 1'b0;
`endif

    logic        clk, rst, load_en, start, pause;
    logic [15:0] load_val;
    logic [15:0] time_bcd;
    logic        running, expired, tick, load_err, warn;

    int nchk = 0;
    int nerr = 0;

    bcd_countdown_timer #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .rst      (rst),
        .load_en  (load_en),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .time_bcd (time_bcd),
        .running  (running),
        .expired  (expired),
        .tick     (tick),
        .load_err (load_err),
        .warn     (warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time as a plain count of seconds, states 0 idle 1 run 2 pause 3 done.
    int m_secs, m_st, m_pre;
    bit m_tick, m_err;

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic bit valid_word(input logic [15:0] v);
        return v[15:12] <= 9 && v[11:8] <= 9 && v[7:4] <= 5 && v[3:0] <= 9;
    endfunction

    function automatic int to_secs(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    always @(posedge clk or posedge rst) begin
        int s, st, pre;
        bit tk, er;
        if (rst) begin
            m_secs <= 0; m_st <= 0; m_pre <= 0; m_tick <= 0; m_err <= 0;
        end else begin
            s = m_secs; st = m_st; pre = m_pre; tk = 0; er = 0;
            if (st != 1 && load_en) begin
                if (valid_word(load_val)) begin
                    s  = to_secs(load_val);
                    st = 0;
                end else begin
                    er = 1;
                end
            end else if (st == 1) begin
                pre = pre + 1;
                if (pre == TD) begin
                    pre = 0;
                    s   = s - 1;
                    tk  = 1;
                end
                if (tk && s == 0) st = 3;
                else if (pause) st = 2;
            end else if ((st == 0 || st == 2) && start && s != 0) begin
                if (st == 0) pre = 0;
                st = 1;
            end
            m_secs <= s; m_st <= st; m_pre <= pre; m_tick <= tk; m_err <= er;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("m_time", time_bcd, to_bcd(m_secs));
        check("m_running", 16'(running), 16'(m_st == 1));
        check("m_expired", 16'(expired), 16'(m_st == 3));
        check("m_tick", 16'(tick), 16'(m_tick));
        check("m_load_err", 16'(load_err), 16'(m_err));
        check("m_warn", 16'(warn),
              16'(WarnOn && (m_st == 1 || m_st == 2) && m_secs >= 1 && m_secs <= 10));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        load_en = 1'b1; load_val = v;
        cyc(1);
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1; cyc(1); pause = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_val = 16'h0000; start = 1'b0; pause = 1'b0;
        cyc(2);
        rst = 1'b0;
        check("reset_time", time_bcd, 16'h0000);
        check("reset_running", 16'(running), 16'd0);

        // Reset and load
        do_load(16'h0130);
        check("load_0130", time_bcd, 16'h0130);
        check("load_idle", 16'(running), 16'd0);

        // Borrow chain
        do_load(16'h1000);
        pulse_start();
        check("start_running", 16'(running), 16'd1);
        cyc(3);
        check("pre_tick_hold", time_bcd, 16'h1000);
        cyc(1);
        check("borrow_0959", time_bcd, 16'h0959);
        check("borrow_tick", 16'(tick), 16'd1);
        cyc(4);
        check("borrow_0958", time_bcd, 16'h0958);
        pulse_pause();
        check("pause_stop", 16'(running), 16'd0);

        // Expiry
        do_load(16'h0002);
        pulse_start();
        cyc(7);
        check("exp_0001", time_bcd, 16'h0001);
        cyc(1);
        check("exp_time", time_bcd, 16'h0000);
        check("exp_flag", 16'(expired), 16'd1);
        check("exp_not_running", 16'(running), 16'd0);
        pulse_start();
        check("exp_start_ignored", 16'(expired), 16'd1);

        // Pause and resume with a partial second
        do_load(16'h0005);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(1);
        pause = 1'b1; cyc(1); pause = 1'b0;
        cyc(20);
        check("pause_hold", time_bcd, 16'h0005);
        pulse_start();
        check("resume_running", 16'(running), 16'd1);
        cyc(1);
        check("resume_no_tick", 16'(tick), 16'd0);
        cyc(1);
        check("resume_tick", 16'(tick), 16'd1);
        check("resume_0004", time_bcd, 16'h0004);

        // Priority and rejected loads
        do_load(16'h0200);
        check("run_load_ignored", time_bcd, 16'h0004);
        start = 1'b1; pause = 1'b1; cyc(1); start = 1'b0; pause = 1'b0;
        check("start_pause_pause", 16'(running), 16'd0);
        do_load(16'h0070);
        check("rej_0070_err", 16'(load_err), 16'd1);
        check("rej_0070_time", time_bcd, 16'h0004);
        cyc(1);
        check("rej_err_pulse", 16'(load_err), 16'd0);
        do_load(16'h00A0);
        check("rej_00A0_err", 16'(load_err), 16'd1);
        check("rej_00A0_time", time_bcd, 16'h0004);
        pulse_pause();

        // Warning window
        do_load(16'h0012);
        pulse_start();
        cyc(7);
        check("warn_0011_time", time_bcd, 16'h0011);
        check("warn_0011", 16'(warn), 16'd0);
        cyc(1);
        check("warn_0010_time", time_bcd, 16'h0010);
        check("warn_0010", 16'(warn), 16'(WarnOn));
        for (int i = 0; i < 60 && !expired; i++) cyc(1);
        check("warn_expire_wait", 16'(expired), 16'd1);
        check("warn_done_low", 16'(warn), 16'd0);

        // Asynchronous reset mid-count
        do_load(16'h0030);
        pulse_start();
        cyc(5);
        #2 rst = 1'b1;
        #1;
        check("async_rst_time", time_bcd, 16'h0000);
        check("async_rst_running", 16'(running), 16'd0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        check("post_rst_time", time_bcd, 16'h0000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

MM:SS countdown stage that holds the four-digit BCD time word. Its `time_bcd` output drives the minute-adjust stage's 16-bit time input. It loads the adjusted word back when that stage asserts its add/sub activity. Between loads it counts down once per second under start/pause control and flags expiry.

## Interface
- `TICK_DIV`, default 50000000: clock cycles per one-second tick; legal range 2 and above.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load_en` in 1: level; while high, `load_val` is captured every cycle.
- `load_val` in 16: BCD word; [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
- `start` in 1: single-cycle request to run or resume.
- `pause` in 1: single-cycle request to pause.
- `time_bcd` out 16: current time, same digit layout as `load_val`.
- `running` out 1: high in RUN.
- `expired` out 1: high in DONE.
- `tick` out 1: one-cycle pulse on each decrement.
- `load_err` out 1: one-cycle pulse when a load is rejected.
- `warn` out 1: last-ten-seconds indicator; see Configuration.

## Operation
- **State machine.** States are IDLE, RUN, PAUSE and DONE. Reset enters IDLE.
- **IDLE or PAUSE, `start` high, time nonzero:** go to RUN. `start` with time 00:00 is ignored.
- **RUN, `pause` high:** go to PAUSE.
- **RUN, tick that produces 00:00:** go to DONE.
- **Any state except RUN, valid load:** go to IDLE. `load_en` is ignored in RUN.
- **Load validation.** A load is rejected when any digit is greater than 9 or the seconds-tens digit is greater than 5. A rejected load leaves the time unchanged and pulses `load_err`; the state does not change.
- **Priority in one cycle.** Order is load, then pause, then start. A `start` in the same cycle as an accepted load is dropped. If `pause` and `start` are both high in RUN, the result is PAUSE.
- **Prescaler.** The counter runs 0..TICK_DIV-1 and advances only in RUN.
  - It clears on any transition into RUN from IDLE.
  - It holds its value through PAUSE, so a resume finishes the partial second.
- **Tick.** A tick fires when the prescaler wraps.
- **Decrement.** A BCD borrow chain:
  - sec ones 0 becomes 9 and borrows from sec tens;
  - sec tens 0 becomes 5 and borrows from min ones;
  - min ones 0 becomes 9 and borrows from min tens.
  - There is no wrap below 00:00, because DONE is entered at 00:00.
- **Maximum value** is 99:59.

## Timing
- **Reset values:** `time_bcd` = 16'h0000; `running`, `expired`, `tick`, `load_err` and `warn` = 0; prescaler = 0.
- **Outputs** are all registered. There is no combinational path from inputs to outputs.
- **Load latency:** `load_val` sampled at edge N appears on `time_bcd` after edge N. A steady `load_en` reloads every cycle, which is harmless.
- **Start:**
  - `running` rises one cycle after `start` is sampled.
  - The first tick comes TICK_DIV cycles after the RUN entry edge.
- **Tick:** `tick` and the new `time_bcd` update on the same edge.
- **Expiry:** `expired` rises on the edge that writes 00:00. `running` falls on that same edge.
- **Reset mid-count** takes effect immediately (asynchronous). It clears the time; it does not retain it.

## Configuration
- **Macro:** `TIMER_WARN_EN`.
- **Defined:** `warn` is high while in RUN or PAUSE with time between 00:01 and 00:10 inclusive. It is registered and updates with `time_bcd`.
- **Undefined:** `warn` is tied to 0 and the comparator is not built. The port stays present, so the interface is identical in both builds.

## Test plan
All scenarios use `TICK_DIV` = 4.
- **Reset and load:** assert `rst`, then load 16'h0130 → `time_bcd` = 0130, state IDLE, `running` = 0.
- **Borrow chain:** load 1000, then `start`.
  - One tick later `time_bcd` = 0959; the next tick gives 0958.
  - Ticks are 4 cycles apart.
- **Expiry:** load 0002, then `start`.
  - After 8 cycles `time_bcd` = 0000 and `expired` = 1 on the same edge that `running` = 0.
  - A further `start` has no effect.
- **Pause/resume:** load 0005, `start`, then `pause` 2 cycles into the period.
  - The time holds at 0005 for 20 cycles.
  - After `start`, the next tick arrives 2 cycles later.
- **Rejected loads and priority:**
  - Loading 0070 or 00A0 → `load_err` pulses and the time is unchanged.
  - Loading during RUN → ignored.
  - `start` and `pause` together in RUN → PAUSE.
- **Warning (`TIMER_WARN_EN` defined):** load 0012, then `start`.
  - `warn` rises when the time reads 0010 and stays high through 0001.
  - It is 0 in DONE.
  - In the build without the macro, `warn` is always 0.
